// File: rtl/ram_sdp_clr.sv
// Simple-dual-port synchronous RAM with per-byte write enables, optional
// output register, write-first read-during-write and a hardware clear sweep
// that initialises every word after reset or on request.
module ram_sdp_clr #(
   parameter int unsigned         DATA_W  = 8,
   parameter int unsigned         ADDR_W  = 6,
   parameter int unsigned         DEPTH   = 64,
   parameter int unsigned         OUT_REG = 0,
   parameter logic [DATA_W-1:0]   CLR_VAL = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   write_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [DATA_W-1:0]      data_in,
   input  logic [DATA_W/8-1:0]    byte_en,
   input  logic                   read_en,
   input  logic [ADDR_W-1:0]      rd_addr,
   input  logic                   clear,
   output logic [DATA_W-1:0]      data_out,
   output logic                   rd_valid,
   output logic                   init_busy
);

   localparam int                 LANES   = int'(DATA_W / 8);
   localparam logic [ADDR_W:0]    DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0]  LAST_C  = ADDR_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                busy_q, busy_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                accept_s;
   logic                wr_in_range_s;
   logic                rd_in_range_s;
   logic                wr_ok_s;
   logic                rd_ok_s;
   logic [DATA_W-1:0]   rd_word_s;

   logic                s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0]   s1_data_q, s1_data_d;

   // Request qualification: nothing is accepted while sweeping or on a clear cycle.
   always_comb begin
      accept_s      = (state_q == ST_READY) && !clear;
      wr_in_range_s = ({1'b0, wr_addr} < DEPTH_C);
      rd_in_range_s = ({1'b0, rd_addr} < DEPTH_C);
      wr_ok_s       = accept_s && write_en && wr_in_range_s;
      rd_ok_s       = accept_s && read_en;
   end

   // Sweep/ready sequencing: next state, sweep address and busy flag.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            if (cnt_q == LAST_C) begin
               state_d = ST_READY;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + ADDR_W'(1);
            end
         end
         ST_READY: begin
            if (clear) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end else begin
               state_d = ST_READY;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == ST_CLEAR);
   end

   // Control registers; reset restarts the sweep from address 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   // Storage array: sweep writes CLR_VAL, normal writes update enabled lanes only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= CLR_VAL;
         end else if (wr_ok_s) begin
            for (int i = 0; i < LANES; i++) begin
               if (byte_en[i]) begin
                  mem_q[wr_addr][8*i +: 8] <= data_in[8*i +: 8];
               end
            end
         end
      end
   end

   // Read word with write-first merge of lanes being written this cycle.
   always_comb begin
      rd_word_s = '0;
      if (rd_in_range_s) begin
         rd_word_s = mem_q[rd_addr];
         for (int i = 0; i < LANES; i++) begin
            if (wr_ok_s && (wr_addr == rd_addr) && byte_en[i]) begin
               rd_word_s[8*i +: 8] = data_in[8*i +: 8];
            end else begin
               rd_word_s[8*i +: 8] = mem_q[rd_addr][8*i +: 8];
            end
         end
      end else begin
         rd_word_s = '0;
      end
   end

   // First read stage next values: capture on accepted read, otherwise hold.
   always_comb begin
      s1_valid_d = rd_ok_s;
      if (rd_ok_s) begin
         s1_data_d = rd_word_s;
      end else begin
         s1_data_d = s1_data_q;
      end
   end

   // First read stage registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic                s2_valid_q, s2_valid_d;
         logic [DATA_W-1:0]   s2_data_q, s2_data_d;

         // Second read stage next values; completes reads regardless of state.
         always_comb begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
               s2_data_d = s1_data_q;
            end else begin
               s2_data_d = s2_data_q;
            end
         end

         // Second read stage registers.
         always_ff @(posedge clk) begin
            if (rst) begin
               s2_valid_q <= 1'b0;
               s2_data_q  <= '0;
            end else begin
               s2_valid_q <= s2_valid_d;
               s2_data_q  <= s2_data_d;
            end
         end

         assign data_out = s2_data_q;
         assign rd_valid = s2_valid_q;
      end else begin : g_no_out_reg
         assign data_out = s1_data_q;
         assign rd_valid = s1_valid_q;
      end
   endgenerate

   assign init_busy = busy_q;

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Directed, table-driven bench for ram_sdp_clr across five parameter sets.
module tb_ram_sdp_clr;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    sel;
   logic          we, re, clr;
   logic [5:0]    wa, ra;
   logic [15:0]   din;
   logic [1:0]    be;

   logic [7:0]    d0, d1, d3, d4;
   logic [15:0]   d2;
   logic [4:0]    rv, bz;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // u0: defaults, u1: CLR_VAL=A5, u2: 16-bit, u3: OUT_REG=1, u4: DEPTH=48
   ram_sdp_clr u0 (.clk(clk), .rst(rst), .write_en(we & sel[0]), .wr_addr(wa), .data_in(din[7:0]),
      .byte_en(be[0:0]), .read_en(re & sel[0]), .rd_addr(ra), .clear(clr & sel[0]),
      .data_out(d0), .rd_valid(rv[0]), .init_busy(bz[0]));
   ram_sdp_clr #(.CLR_VAL(8'hA5)) u1 (.clk(clk), .rst(rst), .write_en(we & sel[1]), .wr_addr(wa),
      .data_in(din[7:0]), .byte_en(be[0:0]), .read_en(re & sel[1]), .rd_addr(ra),
      .clear(clr & sel[1]), .data_out(d1), .rd_valid(rv[1]), .init_busy(bz[1]));
   ram_sdp_clr #(.DATA_W(16)) u2 (.clk(clk), .rst(rst), .write_en(we & sel[2]), .wr_addr(wa),
      .data_in(din), .byte_en(be), .read_en(re & sel[2]), .rd_addr(ra), .clear(clr & sel[2]),
      .data_out(d2), .rd_valid(rv[2]), .init_busy(bz[2]));
   ram_sdp_clr #(.OUT_REG(1)) u3 (.clk(clk), .rst(rst), .write_en(we & sel[3]), .wr_addr(wa),
      .data_in(din[7:0]), .byte_en(be[0:0]), .read_en(re & sel[3]), .rd_addr(ra),
      .clear(clr & sel[3]), .data_out(d3), .rd_valid(rv[3]), .init_busy(bz[3]));
   ram_sdp_clr #(.DEPTH(48)) u4 (.clk(clk), .rst(rst), .write_en(we & sel[4]), .wr_addr(wa),
      .data_in(din[7:0]), .byte_en(be[0:0]), .read_en(re & sel[4]), .rd_addr(ra),
      .clear(clr & sel[4]), .data_out(d4), .rd_valid(rv[4]), .init_busy(bz[4]));

   typedef struct {
      string         name;
      logic [4:0]    sel;
      logic          we;
      logic [5:0]    wa;
      logic [15:0]   din;
      logic [1:0]    be;
      logic          re;
      logic [5:0]    ra;
      int            dut;
      logic          ev;
      logic          cd;
      logic [15:0]   ed;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [15:0] gd(int k);
      case (k)
         0: return {8'h00, d0};
         1: return {8'h00, d1};
         2: return d2;
         3: return {8'h00, d3};
         default: return {8'h00, d4};
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int k, input logic ev, input logic cd,
                      input logic [15:0] ed);
      vectors++;
      if (rv[k] !== ev || (cd && gd(k) !== ed)) begin
         miscompares++;
         $display("FAIL %s: dut%0d rd_valid=%0b data_out=%h, expected rd_valid=%0b data_out=%h%s",
                  name, k, rv[k], gd(k), ev, ed, cd ? "" : " (data not checked)");
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic idle();
      we = 1'b0; re = 1'b0; clr = 1'b0; wa = 6'd0; ra = 6'd0; din = 16'h0000; be = 2'b00;
   endtask

   function automatic vec_t mk(string n, logic [4:0] s, logic w, logic [5:0] a, logic [15:0] d,
                               logic [1:0] b, logic r, logic [5:0] q, int k, logic ev,
                               logic cd, logic [15:0] ed);
      vec_t v;
      v.name = n; v.sel = s; v.we = w; v.wa = a; v.din = d; v.be = b; v.re = r; v.ra = q;
      v.dut = k; v.ev = ev; v.cd = cd; v.ed = ed;
      return v;
   endfunction

   initial begin
      int n[5];
      int err_rv;

      // Sequential access, default params
      tbl.push_back(mk("t1_wr0",  5'b00001, 1'b1, 6'd0, 16'd10, 2'b01, 1'b0, 6'd0, 0, 1'b0, 1'b0, 16'h0));
      tbl.push_back(mk("t1_wr1",  5'b00001, 1'b1, 6'd1, 16'd20, 2'b01, 1'b0, 6'd0, 0, 1'b0, 1'b0, 16'h0));
      tbl.push_back(mk("t1_wr2",  5'b00001, 1'b1, 6'd2, 16'd30, 2'b01, 1'b0, 6'd0, 0, 1'b0, 1'b0, 16'h0));
      tbl.push_back(mk("t1_rd0",  5'b00001, 1'b0, 6'd0, 16'd0,  2'b00, 1'b1, 6'd0, 0, 1'b1, 1'b1, 16'd10));
      tbl.push_back(mk("t1_rd1",  5'b00001, 1'b0, 6'd0, 16'd0,  2'b00, 1'b1, 6'd1, 0, 1'b1, 1'b1, 16'd20));
      tbl.push_back(mk("t1_rd2",  5'b00001, 1'b0, 6'd0, 16'd0,  2'b00, 1'b1, 6'd2, 0, 1'b1, 1'b1, 16'd30));
      tbl.push_back(mk("t1_hold", 5'b00001, 1'b0, 6'd0, 16'd0,  2'b00, 1'b0, 6'd0, 0, 1'b0, 1'b1, 16'd30));
      // Byte enables, 16-bit
      tbl.push_back(mk("t3_wr",   5'b00100, 1'b1, 6'd3, 16'hABCD, 2'b11, 1'b0, 6'd0, 2, 1'b0, 1'b0, 16'h0));
      tbl.push_back(mk("t3_wrlo", 5'b00100, 1'b1, 6'd3, 16'h1234, 2'b01, 1'b0, 6'd0, 2, 1'b0, 1'b0, 16'h0));
      tbl.push_back(mk("t3_rd",   5'b00100, 1'b0, 6'd0, 16'h0,    2'b00, 1'b1, 6'd3, 2, 1'b1, 1'b1, 16'hAB34));
      // Read during write, 16-bit
      tbl.push_back(mk("t4_wr",   5'b00100, 1'b1, 6'd7, 16'hABCD, 2'b11, 1'b0, 6'd0, 2, 1'b0, 1'b0, 16'h0));
      tbl.push_back(mk("t4_rdw",  5'b00100, 1'b1, 6'd7, 16'h1234, 2'b10, 1'b1, 6'd7, 2, 1'b1, 1'b1, 16'h12CD));
      tbl.push_back(mk("t4_rd",   5'b00100, 1'b0, 6'd0, 16'h0,    2'b00, 1'b1, 6'd7, 2, 1'b1, 1'b1, 16'h12CD));
      tbl.push_back(mk("t4_be0",  5'b00100, 1'b1, 6'd3, 16'hFFFF, 2'b00, 1'b1, 6'd3, 2, 1'b1, 1'b1, 16'hAB34));
      // OUT_REG=1 back-to-back
      tbl.push_back(mk("t5_wr0",  5'b01000, 1'b1, 6'd0, 16'd1, 2'b01, 1'b0, 6'd0, 3, 1'b0, 1'b0, 16'h0));
      tbl.push_back(mk("t5_wr1",  5'b01000, 1'b1, 6'd1, 16'd2, 2'b01, 1'b0, 6'd0, 3, 1'b0, 1'b0, 16'h0));
      tbl.push_back(mk("t5_wr2",  5'b01000, 1'b1, 6'd2, 16'd3, 2'b01, 1'b0, 6'd0, 3, 1'b0, 1'b0, 16'h0));
      tbl.push_back(mk("t5_wr3",  5'b01000, 1'b1, 6'd3, 16'd4, 2'b01, 1'b0, 6'd0, 3, 1'b0, 1'b0, 16'h0));
      tbl.push_back(mk("t5_rd0",  5'b01000, 1'b0, 6'd0, 16'd0, 2'b00, 1'b1, 6'd0, 3, 1'b0, 1'b1, 16'd0));
      tbl.push_back(mk("t5_rd1",  5'b01000, 1'b0, 6'd0, 16'd0, 2'b00, 1'b1, 6'd1, 3, 1'b1, 1'b1, 16'd1));
      tbl.push_back(mk("t5_rd2",  5'b01000, 1'b0, 6'd0, 16'd0, 2'b00, 1'b1, 6'd2, 3, 1'b1, 1'b1, 16'd2));
      tbl.push_back(mk("t5_rd3",  5'b01000, 1'b0, 6'd0, 16'd0, 2'b00, 1'b1, 6'd3, 3, 1'b1, 1'b1, 16'd3));
      tbl.push_back(mk("t5_tail", 5'b01000, 1'b0, 6'd0, 16'd0, 2'b00, 1'b0, 6'd0, 3, 1'b1, 1'b1, 16'd4));
      tbl.push_back(mk("t5_hold", 5'b01000, 1'b0, 6'd0, 16'd0, 2'b00, 1'b0, 6'd0, 3, 1'b0, 1'b1, 16'd4));
      // DEPTH=48, out-of-range accesses
      tbl.push_back(mk("t6_wr50", 5'b10000, 1'b1, 6'd50, 16'h77, 2'b01, 1'b0, 6'd0,  4, 1'b0, 1'b0, 16'h0));
      tbl.push_back(mk("t6_rd50", 5'b10000, 1'b0, 6'd0,  16'h0,  2'b00, 1'b1, 6'd50, 4, 1'b1, 1'b1, 16'h00));
      tbl.push_back(mk("t6_wr47", 5'b10000, 1'b1, 6'd47, 16'h47, 2'b01, 1'b0, 6'd0,  4, 1'b0, 1'b1, 16'h00));
      tbl.push_back(mk("t6_rd47", 5'b10000, 1'b0, 6'd0,  16'h0,  2'b00, 1'b1, 6'd47, 4, 1'b1, 1'b1, 16'h47));
      tbl.push_back(mk("t6_rdw50",5'b10000, 1'b1, 6'd50, 16'h99, 2'b01, 1'b1, 6'd50, 4, 1'b1, 1'b1, 16'h00));

      // Reset and initial sweep lengths
      idle();
      sel = 5'b11111;
      rst = 1'b1;
      step();
      chk("reset_state_u0", 0, 1'b0, 1'b1, 16'h0000);
      chk("reset_state_u3", 3, 1'b0, 1'b1, 16'h0000);
      chk_int("reset_busy", int'(bz), 31);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) n[k] = 1;
      for (int c = 0; c < 100; c++) begin
         step();
         if (bz == 5'b00000) break;
         for (int k = 0; k < 5; k++) if (bz[k]) n[k]++;
      end
      chk_int("sweep_len_d64", n[0], 64);
      chk_int("sweep_len_d64_oreg", n[3], 64);
      chk_int("sweep_len_d48", n[4], 48);

      // Table vectors
      foreach (tbl[i]) begin
         sel = tbl[i].sel; we = tbl[i].we; wa = tbl[i].wa; din = tbl[i].din;
         be = tbl[i].be; re = tbl[i].re; ra = tbl[i].ra; clr = 1'b0;
         step();
         chk(tbl[i].name, tbl[i].dut, tbl[i].ev, tbl[i].cd, tbl[i].ed);
      end
      idle();

      // Clear sweep on u0 (CLR_VAL 0) and u1 (CLR_VAL A5)
      sel = 5'b00011;
      we = 1'b1; wa = 6'd5; din = 16'h00FF; be = 2'b01;
      step();
      we = 1'b0; re = 1'b1; ra = 6'd5;
      step();
      chk("t2_pre_u0", 0, 1'b1, 1'b1, 16'h00FF);
      chk("t2_pre_u1", 1, 1'b1, 1'b1, 16'h00FF);
      clr = 1'b1; we = 1'b1; wa = 6'd6; din = 16'h0055; re = 1'b1; ra = 6'd5;
      step();
      chk("t2_clr_cycle", 0, 1'b0, 1'b1, 16'h00FF);
      clr = 1'b0; ra = 6'd6;
      n[0] = bz[0] ? 1 : 0;
      n[1] = bz[1] ? 1 : 0;
      err_rv = 0;
      for (int c = 0; c < 100; c++) begin
         step();
         if (rv[1:0] != 2'b00) err_rv++;
         if (bz[1:0] == 2'b00) break;
         if (bz[0]) n[0]++;
         if (bz[1]) n[1]++;
      end
      chk_int("t2_busy_u0", n[0], 64);
      chk_int("t2_busy_u1", n[1], 64);
      chk_int("t2_no_rd_in_clear", err_rv, 0);
      we = 1'b0; re = 1'b1; ra = 6'd5;
      step();
      chk("t2_rd5_u0", 0, 1'b1, 1'b1, 16'h0000);
      chk("t2_rd5_u1", 1, 1'b1, 1'b1, 16'h00A5);
      ra = 6'd6;
      step();
      chk("t2_rd6_u0", 0, 1'b1, 1'b1, 16'h0000);
      chk("t2_rd6_u1", 1, 1'b1, 1'b1, 16'h00A5);
      idle();

      // OUT_REG=1 reset in the middle of a read stream
      sel = 5'b01000;
      re = 1'b1; ra = 6'd0;
      step();
      chk("t5r_rd0", 3, 1'b0, 1'b1, 16'd4);
      ra = 6'd1;
      step();
      chk("t5r_rd1", 3, 1'b1, 1'b1, 16'd1);
      rst = 1'b1; ra = 6'd2;
      step();
      chk("t5r_rst", 3, 1'b0, 1'b1, 16'd0);
      chk_int("t5r_rst_busy", int'(bz[3]), 1);
      rst = 1'b0; re = 1'b0;
      n[3] = 1;
      for (int c = 0; c < 100; c++) begin
         step();
         if (!bz[3]) break;
         n[3]++;
      end
      chk_int("t5r_sweep_len", n[3], 64);
      re = 1'b1; ra = 6'd2;
      step();
      chk("t5r_post_rd", 3, 1'b0, 1'b1, 16'd0);
      re = 1'b0;
      step();
      chk("t5r_post_val", 3, 1'b1, 1'b1, 16'd0);
      idle();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ram_sdp_clr.md
Name: ram_sdp_clr

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port and one read port on a single clock.
- Adds per-byte write enables, a selectable registered-output read pipeline and write-first read-during-write.
- Includes a hardware clear sweep that initialises every word after reset or on request.
- Serves as the general-purpose storage primitive for 8-bit/6-bit-address and wider memories.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of 8
ADDR_W, 6, address width in bits
DEPTH, 64, number of words; 1 <= DEPTH <= 2**ADDR_W
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
CLR_VAL, 0, DATA_W-bit value written to every word by the clear sweep

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
write_en  input  1  write request
wr_addr  input  ADDR_W  write address
data_in  input  DATA_W  write data
byte_en  input  DATA_W/8  per-byte write mask; bit i covers data_in[8i+7:8i]
read_en  input  1  read request
rd_addr  input  ADDR_W  read address
clear  input  1  request a full clear sweep (single-cycle pulse sufficient)
data_out  output  DATA_W  read data
rd_valid  output  1  high for one cycle when data_out carries the result of a read
init_busy  output  1  high while a clear sweep is in progress

Behaviour:
- Reset: rst sampled high at posedge -> data_out=0, rd_valid=0, pipeline stages cleared, sweep counter=0, state=CLEAR, init_busy=1. rst overrides all other inputs, including mid-sweep and mid-read; the sweep restarts at address 0.
- States: CLEAR, READY.
- CLEAR: one word written per cycle, mem[cnt]<=CLR_VAL, cnt from 0 to DEPTH-1, so the sweep takes exactly DEPTH cycles. After the cycle that writes DEPTH-1, state=READY and init_busy=0. Requests accepted from the first READY cycle.
- In CLEAR, write_en, read_en and clear are ignored, and rd_valid stays 0. Reads already in the pipeline when clear is accepted still complete with their captured data.
- READY with clear=1: no write or read is accepted that cycle. Next cycle state=CLEAR, cnt=0, init_busy=1.
- Write: on posedge with write_en=1 in READY, each lane i with byte_en[i]=1 updates mem[wr_addr][8i+7:8i]. Other lanes are unchanged. byte_en=0 means no change.
- Read: on posedge with read_en=1 in READY, the addressed word is captured.
  - OUT_REG=0: data_out and rd_valid update at the same edge, so data is visible 1 cycle after the request.
  - OUT_REG=1: there is one more stage, so latency is 2.
  - Back-to-back reads give one result per cycle.
- data_out holds its last value when no read completes. rd_valid is 0 in those cycles.
- Read during write, same address, same cycle: write-first. Enabled lanes return data_in; disabled lanes return the old contents.
- Address >= DEPTH (only possible when DEPTH < 2**ADDR_W): the write is dropped; the read returns 0 with rd_valid=1.
- Storage is not reset except through the clear sweep.

Test Plan:
1. Default params, sequential access. Reset, wait 64 cycles until init_busy=0. Write 10@0, 20@1, 30@2 (byte_en=1), then read 0,1,2 on consecutive cycles -> data_out = 10, 20, 30, each one cycle after its request, with rd_valid high for 3 cycles.
2. Clear sweep. Write 0xFF@5. Pulse clear -> init_busy=1 for exactly 64 cycles. A write of 0x55@6 issued during the sweep is ignored. Afterwards, reading 5 and 6 -> 0x00, 0x00. With CLR_VAL=0xA5, the same reads -> 0xA5.
3. Byte enables (DATA_W=16). Write 0xABCD@3 with byte_en=11, then 0x1234@3 with byte_en=01. Read 3 -> 0xAB34.
4. Read during write (DATA_W=16). Old 0xABCD@7. Write 0x1234@7 with byte_en=10 while reading 7 in the same cycle -> 0x12CD.
5. OUT_REG=1. Back-to-back reads of addresses 0..3 holding 1..4 -> data_out 1,2,3,4 with 2-cycle latency and rd_valid high for 4 consecutive cycles. Assert rst mid-stream -> rd_valid=0 and data_out=0 next cycle, and a new sweep starts.
6. DEPTH=48, ADDR_W=6. Write 0x77@50 is dropped. Read 50 -> 0x00 with rd_valid=1. Read 47 after a write of 0x47@47 -> 0x47. Sweep lasts exactly 48 cycles.
